multi_output_stretch: RTL and testbench
=======================================

# multi_output_stretch

Four-channel LED output conditioner. It converts short or glitchy internal status events into human-visible LED levels. Each channel guarantees a minimum on-time and a minimum off-time, so single-cycle events are never lost and back-to-back events stay distinguishable. It sits between the tester's status/command logic and the board LED pins, as the output-side counterpart to the button input debouncing. The four channels are fully independent and have no mutual exclusion.

## Interface
- FCLK, 20000000, system clock frequency in Hz
- ON_MS, 50, minimum LED on-time in milliseconds; c_ON = FCLK*ON_MS/1000 cycles, must be ≥ 2
- OFF_MS, 50, minimum LED off-time in milliseconds; c_OFF = FCLK*OFF_MS/1000 cycles, must be ≥ 2
- i_clk_mhz  input  1  system clock; the only clock
- i_rst_mhz  input  1  reset, asynchronous, active-high
- i_events  input  4  per-channel event/level requests, synchronous to i_clk_mhz (no synchronizer inside)
- o_leds  output  4  per-channel stretched LED drive, active-high

## Operation
- One FSM, one timer and one pending flag per channel. Channel n uses i_events[n] and drives o_leds[n].
- Timer width is sized by $clog2 of max(c_ON, c_OFF). The timer clears on every state change and otherwise increments.
- o_leds[n] is decoded from the registered state only, never directly from i_events: 1 in ST_ON_MIN and ST_ON_HOLD, 0 otherwise.
- ST_IDLE: if i_events[n]=1, go to ST_ON_MIN.
- ST_ON_MIN: the timer counts 0..c_ON-1. At timer = c_ON-1, go to ST_ON_HOLD if i_events[n]=1, else to ST_OFF_MIN. Input toggles before the final cycle are absorbed and do not set pending.
- ST_ON_HOLD: stay while i_events[n]=1. Go to ST_OFF_MIN on the first sampled 0.
- ST_OFF_MIN: the timer counts 0..c_OFF-1. Any sampled i_events[n]=1 in this state sets pending. At timer = c_OFF-1, go to ST_ON_MIN if (pending OR i_events[n]); otherwise go to ST_IDLE.
- pending clears on entry to ST_ON_MIN.
- Illegal state encodings recover to ST_IDLE (safe-state default).
- Reset (async): all states go to ST_IDLE, timers to 0, pending to 0, and o_leds = 4'b0000 immediately without a clock edge. After release, there is no memory of pre-reset events.

## Timing
- Rise latency: an event sampled at edge k gives o_leds[n]=1 from k+1.
- Minimum high: exactly c_ON cycles for any event shorter than c_ON.
- Level input held from k through k+m-1 with m > c_ON: output is high k+1..k+m, low at k+m+1.
- Minimum low after any on-period: exactly c_OFF cycles, then retrigger or idle.
- Events during ST_OFF_MIN: at most one deferred on-period, no matter how many events arrive. It starts the cycle after the off-period ends.
- Simultaneous events on several channels: each channel behaves identically and independently, with no cross-channel priority.
- Reset asserted mid on-period: output drops asynchronously. Reset released with i_events=0: stays idle.

## Test plan
Bench parameters: FCLK=100000, ON_MS=1, OFF_MS=1, so c_ON = c_OFF = 100.
- Reset held 10 cycles, i_events=4'b1111, then released with i_events=0 -> o_leds=0000 throughout and after.
- One-cycle pulse on i_events[0] at edge k -> o_leds[0]=1 on k+1..k+100, 0 on k+101..k+200 and onward; o_leds[3:1]=000.
- i_events[2] high for 300 cycles from k -> o_leds[2]=1 on k+1..k+300, 0 at k+301 and held 0 at least until k+400.
- Pulses on i_events[1] at k, k+150 and k+160 -> on at k+1..k+100, off k+101..k+200, single re-on k+201..k+300, then off and idle (no third on-period).
- Pulses on all four bits at edge k, with a second bit-3 pulse at k+50 -> all four outputs high k+1..k+100 and identical; the bit-3 pulse is absorbed.
- i_rst_mhz asserted between edges at k+40 during a bit-0 on-period -> o_leds[0] falls before the next edge. Release at k+60 with i_events=0 -> o_leds stays 0000.

Source files
------------

// File: rtl/multi_output_stretch.sv
// Four-channel LED stretcher: each channel enforces a minimum on-time and a
// minimum off-time, so short status events become visible LED pulses.
module multi_output_stretch #(
    parameter int FCLK   = 20000000,
    parameter int ON_MS  = 50,
    parameter int OFF_MS = 50
) (
    input  logic       i_clk_mhz,
    input  logic       i_rst_mhz,
    input  logic [3:0] i_events,
    output logic [3:0] o_leds
);
    localparam longint C_ON_L  = (longint'(FCLK) * longint'(ON_MS)) / 1000;
    localparam longint C_OFF_L = (longint'(FCLK) * longint'(OFF_MS)) / 1000;
    localparam int     C_ON    = int'(C_ON_L);
    localparam int     C_OFF   = int'(C_OFF_L);
    localparam int     C_MAX   = (C_ON > C_OFF) ? C_ON : C_OFF;
    localparam int     TW      = (C_MAX > 2) ? $clog2(C_MAX) : 1;

    localparam logic [TW-1:0] ON_LAST  = TW'(C_ON - 1);
    localparam logic [TW-1:0] OFF_LAST = TW'(C_OFF - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ON_MIN  = 2'd1,
        ST_ON_HOLD = 2'd2,
        ST_OFF_MIN = 2'd3
    } state_t;

    state_t          state_q [4];
    state_t          state_d [4];
    logic [TW-1:0]   timer_q [4];
    logic [TW-1:0]   timer_d [4];
    logic [3:0]      pend_q;
    logic [3:0]      pend_d;

    always_comb begin
        for (int n = 0; n < 4; n++) begin
            state_d[n] = state_q[n];
            pend_d[n]  = pend_q[n];
            case (state_q[n])
                ST_IDLE: begin
                    if (i_events[n]) state_d[n] = ST_ON_MIN;
                end
                ST_ON_MIN: begin
                    if (timer_q[n] == ON_LAST)
                        state_d[n] = i_events[n] ? ST_ON_HOLD : ST_OFF_MIN;
                end
                ST_ON_HOLD: begin
                    if (!i_events[n]) state_d[n] = ST_OFF_MIN;
                end
                ST_OFF_MIN: begin
                    if (timer_q[n] == OFF_LAST)
                        state_d[n] = (pend_q[n] || i_events[n]) ? ST_ON_MIN : ST_IDLE;
                    else if (i_events[n])
                        pend_d[n] = 1'b1;
                end
                default: state_d[n] = ST_IDLE;
            endcase
            // Only one deferred on-period is ever owed; entering ON_MIN pays it.
            if (state_d[n] == ST_ON_MIN && state_q[n] != ST_ON_MIN)
                pend_d[n] = 1'b0;
            timer_d[n] = (state_d[n] != state_q[n]) ? '0 : timer_q[n] + TW'(1);
        end
    end

    always_comb begin
        for (int n = 0; n < 4; n++)
            o_leds[n] = (state_q[n] == ST_ON_MIN) || (state_q[n] == ST_ON_HOLD);
    end

    always_ff @(posedge i_clk_mhz or posedge i_rst_mhz) begin
        if (i_rst_mhz) begin
            for (int n = 0; n < 4; n++) begin
                state_q[n] <= ST_IDLE;
                timer_q[n] <= '0;
            end
            pend_q <= '0;
        end else begin
            for (int n = 0; n < 4; n++) begin
                state_q[n] <= state_d[n];
                timer_q[n] <= timer_d[n];
            end
            pend_q <= pend_d;
        end
    end
endmodule

// File: tb/tb_multi_output_stretch.sv
// Scoreboard bench for multi_output_stretch with c_ON = c_OFF = 100 cycles.
module tb_multi_output_stretch;
    logic       clk;
    logic       rst;
    logic [3:0] i_events;
    logic [3:0] o_leds;

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q [$];

    multi_output_stretch #(
        .FCLK   (100000),
        .ON_MS  (1),
        .OFF_MS (1)
    ) dut (
        .i_clk_mhz (clk),
        .i_rst_mhz (rst),
        .i_events  (i_events),
        .o_leds    (o_leds)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sample index j is the output seen after edge k+j-1, matching "k+j" timing labels.
    task automatic test_reset();
        logic [3:0] exp;
        for (int j = 1; j <= 10; j++) begin
            exp_q.push_back(4'b0000);
            @(posedge clk);
            @(negedge clk);
            exp = exp_q.pop_front();
            checks++;
            if (o_leds !== exp) begin
                errors++;
                $display("FAIL reset_hold j=%0d got %b exp %b", j, o_leds, exp);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
        i_events = 4'b0000;
        for (int j = 1; j <= 20; j++) begin
            exp_q.push_back(4'b0000);
            @(negedge clk);
            exp = exp_q.pop_front();
            checks++;
            if (o_leds !== exp) begin
                errors++;
                $display("FAIL reset_release j=%0d got %b exp %b", j, o_leds, exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_single_pulse();
        logic [3:0] exp;
        i_events = 4'b0001;
        for (int j = 1; j <= 250; j++) begin
            @(posedge clk); #1;
            i_events = 4'b0000;
            exp_q.push_back((j <= 100) ? 4'b0001 : 4'b0000);
            @(negedge clk);
            exp = exp_q.pop_front();
            checks++;
            if (o_leds !== exp) begin
                errors++;
                $display("FAIL single_pulse j=%0d got %b exp %b", j, o_leds, exp);
            end
        end
    endtask

    task automatic test_level_hold();
        logic [3:0] exp;
        i_events = 4'b0100;
        for (int j = 1; j <= 420; j++) begin
            @(posedge clk); #1;
            i_events = (j < 300) ? 4'b0100 : 4'b0000;
            exp_q.push_back((j <= 300) ? 4'b0100 : 4'b0000);
            @(negedge clk);
            exp = exp_q.pop_front();
            checks++;
            if (o_leds !== exp) begin
                errors++;
                $display("FAIL level_hold j=%0d got %b exp %b", j, o_leds, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp;
        i_events = 4'b0010;
        for (int j = 1; j <= 450; j++) begin
            @(posedge clk); #1;
            i_events = (j == 150 || j == 160) ? 4'b0010 : 4'b0000;
            exp_q.push_back(((j >= 1 && j <= 100) || (j >= 201 && j <= 300)) ? 4'b0010 : 4'b0000);
            @(negedge clk);
            exp = exp_q.pop_front();
            checks++;
            if (o_leds !== exp) begin
                errors++;
                $display("FAIL back_to_back j=%0d got %b exp %b", j, o_leds, exp);
            end
        end
    endtask

    task automatic test_all_channels();
        logic [3:0] exp;
        i_events = 4'b1111;
        for (int j = 1; j <= 250; j++) begin
            @(posedge clk); #1;
            i_events = (j == 50) ? 4'b1000 : 4'b0000;
            exp_q.push_back((j <= 100) ? 4'b1111 : 4'b0000);
            @(negedge clk);
            exp = exp_q.pop_front();
            checks++;
            if (o_leds !== exp) begin
                errors++;
                $display("FAIL all_channels j=%0d got %b exp %b", j, o_leds, exp);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [3:0] exp;
        i_events = 4'b0001;
        for (int j = 1; j <= 40; j++) begin
            @(posedge clk); #1;
            i_events = 4'b0000;
            exp_q.push_back(4'b0001);
            @(negedge clk);
            exp = exp_q.pop_front();
            checks++;
            if (o_leds !== exp) begin
                errors++;
                $display("FAIL mid_reset_on j=%0d got %b exp %b", j, o_leds, exp);
            end
        end
        #2;
        rst = 1'b1;
        exp_q.push_back(4'b0000);
        #1;
        exp = exp_q.pop_front();
        checks++;
        if (o_leds !== exp) begin
            errors++;
            $display("FAIL mid_reset_async got %b exp %b", o_leds, exp);
        end
        for (int j = 41; j <= 60; j++) begin
            @(posedge clk); #1;
            if (j == 60) rst = 1'b0;
            exp_q.push_back(4'b0000);
            @(negedge clk);
            exp = exp_q.pop_front();
            checks++;
            if (o_leds !== exp) begin
                errors++;
                $display("FAIL mid_reset_held j=%0d got %b exp %b", j, o_leds, exp);
            end
        end
        for (int j = 1; j <= 150; j++) begin
            @(posedge clk); #1;
            exp_q.push_back(4'b0000);
            @(negedge clk);
            exp = exp_q.pop_front();
            checks++;
            if (o_leds !== exp) begin
                errors++;
                $display("FAIL mid_reset_after j=%0d got %b exp %b", j, o_leds, exp);
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        i_events = 4'b1111;
        test_reset();
        test_single_pulse();
        test_level_hold();
        test_back_to_back();
        test_all_channels();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
